// File: rtl/acc_pkg.sv
// Shared types for the accumulator core control path: FSM state encoding and flag layout.
package acc_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StWriteback = 3'd4,
    StIntSave   = 3'd5,
    StIntVector = 3'd6,
    StHalt      = 3'd7
  } state_e;

  localparam int unsigned FlagW       = 3;
  localparam int unsigned FlagCoutBit = 2;
  localparam int unsigned FlagZeroBit = 1;
  localparam int unsigned FlagOvfBit  = 0;

endpackage

// File: rtl/acc_edge_latch.sv
// Rising-edge detector feeding a sticky pending bit; a new edge beats a simultaneous clear.
module acc_edge_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  input  logic clr_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q, pend_d;
  logic rise;

  assign rise   = d_i & ~prev_q;
  assign pend_d = rise | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= d_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/acc_stage_sequencer.sv
// Fetch/decode/execute/writeback sequencer with a single-level interrupt and PC/flag shadows.
module acc_stage_sequencer
  import acc_pkg::*;
#(
  parameter int unsigned    PcW       = 8,
  parameter logic [PcW-1:0] IntVector = 'hF0,
  parameter logic           ResetIe   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             interrupt_i,
  input  logic             mem_ready_i,
  input  logic             op_halt_i,
  input  logic             op_reti_i,
  input  logic             op_ei_i,
  input  logic             op_di_i,
  input  logic [PcW-1:0]   pc_i,
  input  logic [FlagW-1:0] flags_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             wb_en_o,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic [PcW-1:0]   pc_load_val_o,
  output logic             flags_restore_o,
  output logic [FlagW-1:0] flags_saved_o,
  output logic             stage_complete_o,
  output logic             int_ack_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic             halt_q, halt_d, reti_q, reti_d, ei_q, ei_d, di_q, di_d;
  logic             ie_q, ie_d, in_isr_q, in_isr_d;
  logic [PcW-1:0]   saved_pc_q, saved_pc_d;
  logic [FlagW-1:0] flags_saved_q, flags_saved_d;
  logic             start_pend, int_pend;

  // Start only matters in IDLE, and IDLE is never re-entered without reset.
  acc_edge_latch u_start_latch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (start_i),
    .clr_i  (state_q != StIdle),
    .pend_o (start_pend)
  );

  acc_edge_latch u_int_latch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (interrupt_i),
    .clr_i  (state_q == StIntSave),
    .pend_o (int_pend)
  );

  always_comb begin
    state_d          = state_q;
    halt_d           = halt_q;
    reti_d           = reti_q;
    ei_d             = ei_q;
    di_d             = di_q;
    ie_d             = ie_q;
    in_isr_d         = in_isr_q;
    saved_pc_d       = saved_pc_q;
    flags_saved_d    = flags_saved_q;
    fetch_en_o       = 1'b0;
    decode_en_o      = 1'b0;
    exec_en_o        = 1'b0;
    wb_en_o          = 1'b0;
    pc_inc_o         = 1'b0;
    pc_load_o        = 1'b0;
    pc_load_val_o    = '0;
    flags_restore_o  = 1'b0;
    stage_complete_o = 1'b0;
    int_ack_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_pend) state_d = StFetch;
      end
      StFetch: begin
        fetch_en_o = 1'b1;
        if (mem_ready_i) begin
          pc_inc_o = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        decode_en_o = 1'b1;
        halt_d      = op_halt_i;
        reti_d      = op_reti_i;
        ei_d        = op_ei_i;
        di_d        = op_di_i;
        state_d     = StExecute;
      end
      StExecute: begin
        exec_en_o = 1'b1;
        if (ei_q)      ie_d = 1'b1;
        else if (di_q) ie_d = 1'b0;
        state_d = StWriteback;
      end
      StWriteback: begin
        wb_en_o          = 1'b1;
        stage_complete_o = 1'b1;
        // RETI outside an ISR falls through as a NOP.
        if (reti_q && in_isr_q) begin
          pc_load_o       = 1'b1;
          pc_load_val_o   = saved_pc_q;
          flags_restore_o = 1'b1;
          in_isr_d        = 1'b0;
          ie_d            = 1'b1;
        end
        // Use post-RETI ie/in_isr so a request held off during the ISR is taken right here.
        if (halt_q)                              state_d = StHalt;
        else if (int_pend && ie_d && !in_isr_d)  state_d = StIntSave;
        else                                     state_d = StFetch;
      end
      StIntSave: begin
        saved_pc_d    = pc_i;
        flags_saved_d = flags_i;
        ie_d          = 1'b0;
        in_isr_d      = 1'b1;
        state_d       = StIntVector;
      end
      StIntVector: begin
        pc_load_o     = 1'b1;
        pc_load_val_o = IntVector;
        int_ack_o     = 1'b1;
        state_d       = StFetch;
      end
      StHalt: begin
        if (int_pend && ie_q) state_d = StIntSave;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q != StIdle) && (state_q != StHalt);
  assign flags_saved_o = flags_saved_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      halt_q        <= 1'b0;
      reti_q        <= 1'b0;
      ei_q          <= 1'b0;
      di_q          <= 1'b0;
      ie_q          <= ResetIe;
      in_isr_q      <= 1'b0;
      saved_pc_q    <= '0;
      flags_saved_q <= '0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      reti_q        <= reti_d;
      ei_q          <= ei_d;
      di_q          <= di_d;
      ie_q          <= ie_d;
      in_isr_q      <= in_isr_d;
      saved_pc_q    <= saved_pc_d;
      flags_saved_q <= flags_saved_d;
    end
  end

endmodule

// File: tb/tb_acc_stage_sequencer.sv
// Directed bench for acc_stage_sequencer: stage stepping, fetch stall, interrupt entry/exit, halt.
module tb_acc_stage_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0, interrupt_i = 1'b0, mem_ready_i = 1'b1;
  logic       op_halt_i = 1'b0, op_reti_i = 1'b0, op_ei_i = 1'b0, op_di_i = 1'b0;
  logic [7:0] pc_i = 8'h00;
  logic [2:0] flags_i = 3'b000;
  logic       fetch_en_o, decode_en_o, exec_en_o, wb_en_o, pc_inc_o, pc_load_o;
  logic [7:0] pc_load_val_o;
  logic       flags_restore_o, stage_complete_o, int_ack_o, busy_o;
  logic [2:0] flags_saved_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  acc_stage_sequencer #(
    .PcW       (8),
    .IntVector (8'hF0),
    .ResetIe   (1'b1)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .interrupt_i      (interrupt_i),
    .mem_ready_i      (mem_ready_i),
    .op_halt_i        (op_halt_i),
    .op_reti_i        (op_reti_i),
    .op_ei_i          (op_ei_i),
    .op_di_i          (op_di_i),
    .pc_i             (pc_i),
    .flags_i          (flags_i),
    .fetch_en_o       (fetch_en_o),
    .decode_en_o      (decode_en_o),
    .exec_en_o        (exec_en_o),
    .wb_en_o          (wb_en_o),
    .pc_inc_o         (pc_inc_o),
    .pc_load_o        (pc_load_o),
    .pc_load_val_o    (pc_load_val_o),
    .flags_restore_o  (flags_restore_o),
    .flags_saved_o    (flags_saved_o),
    .stage_complete_o (stage_complete_o),
    .int_ack_o        (int_ack_o),
    .busy_o           (busy_o)
  );

  function automatic logic [21:0] all_outs();
    return {fetch_en_o, decode_en_o, exec_en_o, wb_en_o, pc_inc_o, pc_load_o, pc_load_val_o,
            flags_restore_o, flags_saved_o, stage_complete_o, int_ack_o, busy_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // From FETCH with mem_ready high: ends #1 after entering WRITEBACK.
  task automatic run_instr(input logic h, input logic r, input logic e, input logic d);
    step();
    op_halt_i = h; op_reti_i = r; op_ei_i = e; op_di_i = d;
    step();
    op_halt_i = 0; op_reti_i = 0; op_ei_i = 0; op_di_i = 0;
    step();
  endtask

  // Ends #1 after entering FETCH.
  task automatic boot();
    start_i = 1'b1;
    step();
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    vectors++;
    if (all_outs() !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    step();
    rst_ni = 1'b1;
    step();
    step();
    vectors++;
    if (busy_o !== 1'b0 || fetch_en_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_without_start: busy=%b fetch_en=%b want 0 0", busy_o, fetch_en_o);
    end
  endtask

  task automatic test_start_rate();
    logic [11:0] sc_mask = '0;
    start_i = 1'b1;
    step();
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latch_cycle: busy=%b want 0", busy_o);
    end
    step();
    vectors++;
    if (fetch_en_o !== 1'b1 || pc_inc_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_fetch: fetch_en=%b pc_inc=%b busy=%b want 1 1 1",
               fetch_en_o, pc_inc_o, busy_o);
    end
    step();
    start_i = 1'b0;
    vectors++;
    if ({fetch_en_o, decode_en_o, exec_en_o, wb_en_o} !== 4'b0100) begin
      miscompares++;
      $display("FAIL decode_stage: enables=%b want 0100",
               {fetch_en_o, decode_en_o, exec_en_o, wb_en_o});
    end
    step();
    vectors++;
    if ({fetch_en_o, decode_en_o, exec_en_o, wb_en_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL exec_stage: enables=%b want 0010",
               {fetch_en_o, decode_en_o, exec_en_o, wb_en_o});
    end
    step();
    vectors++;
    if ({wb_en_o, stage_complete_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL wb_stage: wb_en,stage_complete=%b want 11", {wb_en_o, stage_complete_o});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      sc_mask[i] = stage_complete_o;
    end
    vectors++;
    if (sc_mask !== 12'b1000_1000_1000) begin
      miscompares++;
      $display("FAIL stage_complete_rate: mask=%b want 100010001000", sc_mask);
    end
    step();
  endtask

  task automatic test_fetch_stall();
    int incs = 0;
    int held = 0;
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      held += int'(fetch_en_o);
      incs += int'(pc_inc_o);
      step();
    end
    mem_ready_i = 1'b1;
    held += int'(fetch_en_o);
    incs += int'(pc_inc_o);
    step();
    vectors++;
    if (held !== 4 || incs !== 1) begin
      miscompares++;
      $display("FAIL fetch_stall: fetch_cycles=%0d pc_incs=%0d want 4 1", held, incs);
    end
    vectors++;
    if (decode_en_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_then_decode: decode_en=%b want 1", decode_en_o);
    end
    step();
    step();
    step();
  endtask

  task automatic test_interrupt();
    pc_i = 8'h12;
    flags_i = 3'b101;
    interrupt_i = 1'b1;
    run_instr(0, 0, 0, 0);
    interrupt_i = 1'b0;
    vectors++;
    if (stage_complete_o !== 1'b1 || int_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL int_wb: stage_complete=%b int_ack=%b want 1 0", stage_complete_o, int_ack_o);
    end
    step();
    vectors++;
    if (busy_o !== 1'b1 || fetch_en_o !== 1'b0 || int_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL int_save: busy=%b fetch_en=%b int_ack=%b want 1 0 0",
               busy_o, fetch_en_o, int_ack_o);
    end
    step();
    vectors++;
    if ({int_ack_o, pc_load_o, pc_load_val_o, flags_saved_o} !== {1'b1, 1'b1, 8'hF0, 3'b101})
    begin
      miscompares++;
      $display("FAIL int_vector: ack=%b load=%b val=%h flags_saved=%b want 1 1 f0 101",
               int_ack_o, pc_load_o, pc_load_val_o, flags_saved_o);
    end
    step();
    pc_i = 8'hF1;
    flags_i = 3'b010;
    run_instr(0, 1, 0, 0);
    vectors++;
    if ({pc_load_o, pc_load_val_o, flags_restore_o} !== {1'b1, 8'h12, 1'b1}) begin
      miscompares++;
      $display("FAIL reti_restore: load=%b val=%h restore=%b want 1 12 1",
               pc_load_o, pc_load_val_o, flags_restore_o);
    end
    step();
    vectors++;
    if (fetch_en_o !== 1'b1 || int_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reti_resume: fetch_en=%b int_ack=%b want 1 0", fetch_en_o, int_ack_o);
    end
  endtask

  task automatic test_nested();
    pc_i = 8'h34;
    flags_i = 3'b011;
    interrupt_i = 1'b1;
    run_instr(0, 0, 0, 0);
    interrupt_i = 1'b0;
    step();
    step();
    step();
    pc_i = 8'h35;
    interrupt_i = 1'b1;
    run_instr(0, 0, 0, 0);
    interrupt_i = 1'b0;
    step();
    vectors++;
    if (fetch_en_o !== 1'b1 || int_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL no_nesting: fetch_en=%b int_ack=%b want 1 0", fetch_en_o, int_ack_o);
    end
    run_instr(0, 1, 0, 0);
    vectors++;
    if ({pc_load_o, pc_load_val_o, int_ack_o} !== {1'b1, 8'h34, 1'b0}) begin
      miscompares++;
      $display("FAIL nested_reti: load=%b val=%h ack=%b want 1 34 0",
               pc_load_o, pc_load_val_o, int_ack_o);
    end
    step();
    vectors++;
    if (int_ack_o !== 1'b0 || fetch_en_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_save: ack=%b fetch_en=%b busy=%b want 0 0 1",
               int_ack_o, fetch_en_o, busy_o);
    end
    step();
    vectors++;
    if (int_ack_o !== 1'b1 || pc_load_val_o !== 8'hF0) begin
      miscompares++;
      $display("FAIL pending_taken: ack=%b val=%h want 1 f0", int_ack_o, pc_load_val_o);
    end
    step();
    run_instr(0, 1, 0, 0);
    vectors++;
    if (pc_load_val_o !== 8'h35) begin
      miscompares++;
      $display("FAIL second_reti: val=%h want 35", pc_load_val_o);
    end
    step();
  endtask

  task automatic test_di_ei();
    run_instr(0, 0, 0, 1);
    step();
    interrupt_i = 1'b1;
    run_instr(0, 0, 0, 0);
    interrupt_i = 1'b0;
    step();
    vectors++;
    if (fetch_en_o !== 1'b1 || int_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL masked_int: fetch_en=%b ack=%b want 1 0", fetch_en_o, int_ack_o);
    end
    pc_i = 8'h40;
    run_instr(0, 0, 1, 0);
    step();
    step();
    vectors++;
    if (int_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ei_takes_pending: ack=%b want 1", int_ack_o);
    end
    step();
    run_instr(0, 1, 0, 0);
    vectors++;
    if (pc_load_val_o !== 8'h40) begin
      miscompares++;
      $display("FAIL ei_reti: val=%h want 40", pc_load_val_o);
    end
    step();
  endtask

  task automatic test_halt();
    int busy_seen = 0;
    pc_i = 8'h56;
    run_instr(1, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      busy_seen += int'(busy_o | fetch_en_o | decode_en_o | exec_en_o | wb_en_o);
      step();
    end
    vectors++;
    if (busy_seen !== 0) begin
      miscompares++;
      $display("FAIL halt_idle: active_cycles=%0d want 0", busy_seen);
    end
    interrupt_i = 1'b1;
    step();
    interrupt_i = 1'b0;
    step();
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_wake: busy=%b want 1", busy_o);
    end
    step();
    step();
    run_instr(0, 1, 0, 0);
    vectors++;
    if (pc_load_val_o !== 8'h56) begin
      miscompares++;
      $display("FAIL halt_resume: val=%h want 56", pc_load_val_o);
    end
    step();
  endtask

  task automatic test_halt_masked();
    int busy_seen = 0;
    run_instr(0, 0, 0, 1);
    step();
    run_instr(1, 0, 0, 0);
    step();
    interrupt_i = 1'b1;
    step();
    interrupt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      busy_seen += int'(busy_o);
      step();
    end
    vectors++;
    if (busy_seen !== 0) begin
      miscompares++;
      $display("FAIL halt_masked: busy_cycles=%0d want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    boot();
    step();
    step();
    vectors++;
    if (exec_en_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_execute: exec_en=%b want 1", exec_en_o);
    end
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== 22'd0) begin
      miscompares++;
      $display("FAIL async_reset: outs=%h want 0", all_outs());
    end
    step();
    rst_ni = 1'b1;
    step();
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
    boot();
    run_instr(0, 0, 0, 0);
    step();
    vectors++;
    if (fetch_en_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_clears_pending: fetch_en=%b want 1", fetch_en_o);
    end
  endtask

  initial begin
    test_reset();
    test_start_rate();
    test_fetch_stall();
    test_interrupt();
    test_nested();
    test_di_ei();
    test_halt();
    test_halt_masked();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
